idli_fetch_m: RTL and testbench
===============================

Name: idli_fetch_m

Overview:
Instruction fetch stage directly upstream of the nibble-serial decoder. Drives the external SQI memory: chip select, read command, address, dummy cycles, then a continuous data stream. Delivers each 16-bit instruction to decode as 4 consecutive nibbles with a valid flag, and tracks the fetch PC. Handles redirects (branches), stalls at instruction boundaries, and PC wrap.

Parameters:
RESET_PC, 16'h0000, word address fetched after reset.
ADDR_NIBBLES, 6, SQI address length in nibbles (24-bit byte address).
DUMMY_CYCLES, 2, SQI read dummy cycles (SIO tri-stated).
SQI_READ_CMD, 8'h03, read opcode sent as 2 nibbles, MSN first.

Ports:
i_fch_gck  in  1  core clock; SQI SCK is derived from it externally, one nibble per cycle.
i_fch_rst  in  1  synchronous, active-high reset.
i_fch_stall  in  1  back-end not ready; sampled only at instruction boundaries.
i_fch_redirect  in  1  branch taken; abort the burst and refetch from i_fch_redirect_pc.
i_fch_redirect_pc  in  16  target word address.
o_fch_sqi_cs_n  out  1  memory chip select, active low.
o_fch_sqi_sio_out  out  4  nibble driven to memory.
o_fch_sqi_sio_oe  out  1  SIO output enable.
i_fch_sqi_sio_in  in  4  nibble from memory.
o_fch_enc  out  4  instruction nibble to decode (feeds i_dcd_enc).
o_fch_enc_vld  out  1  nibble valid (feeds i_dcd_enc_vld).
o_fch_pc  out  16  word address of the instruction currently on o_fch_enc.

Behaviour:
- Clock and reset: single clock i_fch_gck. i_fch_rst is synchronous and active-high.
- Reset values: cs_n=1, sio_oe=0, sio_out=0, enc=0, enc_vld=0, o_fch_pc=RESET_PC, state=IDLE, nibble index=0.
- Reset asserted mid-operation: these values appear on the next edge, regardless of state.
- State machine: IDLE -> CMD (2 cyc) -> ADDR (ADDR_NIBBLES cyc) -> DUMMY (DUMMY_CYCLES cyc) -> DATA (unbounded).
- IDLE: cs_n=1. Lasts exactly 1 cycle, then CMD, unless i_fch_stall=1; while stalled, remain in IDLE.
- CMD: cs_n=0, oe=1. sio_out = SQI_READ_CMD[7:4], then SQI_READ_CMD[3:0].
- ADDR: oe=1. Sends byte address {pad zeros, fetch_pc, 1'b0}, MSN first, zero-extended to ADDR_NIBBLES*4 bits.
- DUMMY: cs_n=0, oe=0, sio_out=0.
- DATA: cs_n=0, oe=0.
  - i_fch_sqi_sio_in is registered: o_fch_enc and o_fch_enc_vld=1 appear 1 cycle after the nibble is on the bus.
  - A 2-bit nibble index counts 0..3. Nibble 0 is the first nibble in memory order.
  - o_fch_pc increments (mod 2^16) on the cycle after nibble 3 is delivered.
- Latency: CS falls 1 cycle after reset deasserts. The first o_fch_enc_vld is 2+ADDR_NIBBLES+DUMMY_CYCLES+1 cycles after CS falls (11 cycles at defaults).
- Valid contiguity: once nibble 0 is valid, nibbles 1-3 follow in consecutive cycles. Valid never drops mid-instruction except on redirect or reset.
- Stall: sampled in the cycle nibble 3 is on the bus.
  - If 1: the burst ends, cs_n=1 next cycle, FSM goes to IDLE and holds the next PC.
  - On release: full CMD/ADDR/DUMMY restart from the held PC.
  - Otherwise: streaming continues, so back-to-back instructions arrive every 4 cycles with no gap.
- Redirect: highest priority below reset, accepted in any state.
  - Next cycle: cs_n=1, enc_vld=0, fetch PC = i_fch_redirect_pc, nibble index=0, state=IDLE.
  - Any partial instruction is discarded. Flushing decode on the same event is the integration's responsibility.
  - Redirect and stall in the same cycle: redirect wins, then stall governs the IDLE exit.
- PC wrap: when nibble 3 of PC 16'hFFFF is delivered, the burst ends (cs_n=1) and restarts at PC 0 with a full command.
- Counters: one down-counter, wide enough for max(ADDR_NIBBLES, DUMMY_CYCLES), sequences the CMD/ADDR/DUMMY phases. It is reloaded on each state entry.

Decomposition:
- idli_pkg: fetch state enum typedef (IDLE, CMD, ADDR, DUMMY, DATA), SQI_READ_CMD, ADDR_NIBBLES and DUMMY_CYCLES defaults, instruction width (16) and nibbles-per-instruction (4) constants.
- Single module. Address-nibble selection and the phase counter are inline; no sub-module is warranted.

Test Plan:
- Reset release, memory model holding 16'hA5C3 at word 0:
  - cs_n low 1 cycle after release.
  - sio_out sequence 0,3,0,0,0,0,0,0, then 2 cycles with oe=0.
  - enc 4 consecutive valid nibbles in memory order starting 11 cycles after CS low, with o_fch_pc=0.
- Streaming, stall held 0: instructions at PCs 0,1,2 are delivered back-to-back (12 consecutive valid cycles), o_fch_pc steps 0->1->2, cs_n stays low.
- Stall asserted during nibble 3 of PC 5, held 3 cycles:
  - cs_n high next cycle.
  - No valid during the stall.
  - After release, ADDR phase sends byte address 0x00000C, then PC 6 is delivered.
- Redirect to 16'h1234 during nibble 1 of PC 2:
  - Next cycle enc_vld=0, cs_n=1.
  - Restart ADDR sends 0,0,2,4,6,8; first delivered instruction has o_fch_pc=16'h1234.
- Redirect to 16'hFFFF: after nibble 3, cs_n rises, a new command is issued with address 0, and o_fch_pc=0.
- Reset asserted mid-DATA (nibble 2): next cycle all outputs equal reset values. A fresh fetch from RESET_PC follows release.

Source files
------------

// File: rtl/idli_pkg.sv
// idli_pkg: shared fetch-stage types and SQI defaults
package idli_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} fch_state_t;
  localparam int INSN_W = 16;
  localparam int INSN_NIBBLES = INSN_W / 4;
  localparam int DEF_ADDR_NIBBLES = 6;
  localparam int DEF_DUMMY_CYCLES = 2;
  localparam logic [7:0] DEF_SQI_READ_CMD = 8'h03;
endpackage

// File: rtl/idli_fetch_m.sv
// idli_fetch_m: SQI read-burst fetch delivering 16-bit instructions to decode as nibbles
module idli_fetch_m
  import idli_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int ADDR_NIBBLES = DEF_ADDR_NIBBLES,
  parameter int DUMMY_CYCLES = DEF_DUMMY_CYCLES,
  parameter logic [7:0] SQI_READ_CMD = DEF_SQI_READ_CMD
) (
  input  logic        i_fch_gck,
  input  logic        i_fch_rst,
  input  logic        i_fch_stall,
  input  logic        i_fch_redirect,
  input  logic [15:0] i_fch_redirect_pc,
  output logic        o_fch_sqi_cs_n,
  output logic [3:0]  o_fch_sqi_sio_out,
  output logic        o_fch_sqi_sio_oe,
  input  logic [3:0]  i_fch_sqi_sio_in,
  output logic [3:0]  o_fch_enc,
  output logic        o_fch_enc_vld,
  output logic [15:0] o_fch_pc
);
  localparam int ADDR_W = ADDR_NIBBLES * 4;
  localparam int PH_MAX = ADDR_NIBBLES > DUMMY_CYCLES ? ADDR_NIBBLES : DUMMY_CYCLES;
  localparam int CNT_W = PH_MAX > 2 ? $clog2(PH_MAX) : 1;
  fch_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0] idx;
  logic inc;
  logic last;
  logic [ADDR_W-1:0] addr;
  assign addr = ADDR_W'({o_fch_pc, 1'b0});
  assign last = idx == 2'(INSN_NIBBLES - 1);
  assign o_fch_sqi_cs_n = state == IDLE;
  assign o_fch_sqi_sio_oe = state inside {CMD, ADDR};
  assign o_fch_sqi_sio_out = state == CMD ? (cnt[0] ? SQI_READ_CMD[7:4] : SQI_READ_CMD[3:0]) :
                             state == ADDR ? 4'(addr >> {cnt, 2'b00}) : 4'h0;
  always_comb begin
    state_n = state;
    cnt_n = cnt - CNT_W'(1);
    unique case (state)
      IDLE: begin
        state_n = i_fch_stall ? IDLE : CMD;
        cnt_n = CNT_W'(1);
      end
      CMD: if (cnt == '0) begin
        state_n = ADDR;
        cnt_n = CNT_W'(ADDR_NIBBLES - 1);
      end
      ADDR: if (cnt == '0) begin
        state_n = DUMMY;
        cnt_n = CNT_W'(DUMMY_CYCLES - 1);
      end
      DUMMY: state_n = cnt == '0 ? DATA : DUMMY;
      DATA: state_n = last && (i_fch_stall || &o_fch_pc) ? IDLE : DATA;
      default: state_n = IDLE;
    endcase
    if (i_fch_redirect) state_n = IDLE;
  end
  always_ff @(posedge i_fch_gck) begin
    if (i_fch_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      inc <= 1'b0;
      o_fch_enc <= '0;
      o_fch_enc_vld <= 1'b0;
      o_fch_pc <= RESET_PC;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= state == DATA && !i_fch_redirect ? idx + 2'd1 : 2'd0;
      inc <= state == DATA && last && !i_fch_redirect;
      o_fch_enc_vld <= state == DATA && !i_fch_redirect;
      if (state == DATA) o_fch_enc <= i_fch_sqi_sio_in;
      o_fch_pc <= i_fch_redirect ? i_fch_redirect_pc : inc ? o_fch_pc + 16'd1 : o_fch_pc;
    end
  end
endmodule

// File: tb/tb_idli_fetch_m.sv
// tb_idli_fetch_m: SQI memory model plus instruction-stream scoreboard for idli_fetch_m
module tb_idli_fetch_m;
  import idli_pkg::*;
  localparam logic [15:0] RESET_PC = 16'h0000;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic cs_n, sio_oe, enc_vld;
  logic [3:0] sio_out, enc;
  logic [3:0] sio_in = '0;
  logic [15:0] pc;
  int checks = 0, fails = 0;
  logic [15:0] ep = RESET_PC;
  int en = 0;
  int n = 0;
  logic [7:0] cmd_cap = '0;
  logic [23:0] addr_cap = '0;
  logic [15:0] salt = '0;

  always #5 clk = ~clk;

  idli_fetch_m dut (
    .i_fch_gck(clk), .i_fch_rst(rst), .i_fch_stall(stall), .i_fch_redirect(redirect),
    .i_fch_redirect_pc(redirect_pc), .o_fch_sqi_cs_n(cs_n), .o_fch_sqi_sio_out(sio_out),
    .o_fch_sqi_sio_oe(sio_oe), .i_fch_sqi_sio_in(sio_in), .o_fch_enc(enc),
    .o_fch_enc_vld(enc_vld), .o_fch_pc(pc)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] w);
    logic [15:0] t;
    t = w * 16'h3B9D;
    return w == 16'h0000 ? 16'hA5C3 : t ^ salt;
  endfunction

  function automatic logic [3:0] mem_nib(input logic [15:0] w, input int i);
    logic [15:0] d;
    d = mem_word(w);
    return d[4*(3-i) +: 4];
  endfunction

  // Scoreboard: every delivered nibble must be the next nibble of the expected instruction
  // stream; the memory model decodes the command/address from the bus and streams data.
  always @(negedge clk) begin
    if (enc_vld === 1'b1) begin
      checks++;
      if (enc !== mem_nib(ep, en) || pc !== ep) begin
        fails++;
        $display("FAIL stream: enc=%h pc=%h, required enc=%h pc=%h", enc, pc, mem_nib(ep, en), ep);
      end
      en++;
      if (en == 4) begin
        en = 0;
        ep++;
      end
    end else if (en != 0) begin
      checks++;
      fails++;
      $display("FAIL contiguity: valid=0 at nibble %0d of pc %h, required valid=1", en, ep);
      en = 0;
    end
    if (cs_n !== 1'b0) begin
      n = 0;
      sio_in = '0;
    end else begin
      if (n < 2) cmd_cap = {cmd_cap[3:0], sio_out};
      else if (n < 8) addr_cap = {addr_cap[19:0], sio_out};
      checks++;
      if (sio_oe !== (n < 8)) begin
        fails++;
        $display("FAIL sio_oe: cycle %0d of burst oe=%b, required %b", n, sio_oe, n < 8);
      end
      if (n == 1) begin
        checks++;
        if (cmd_cap !== DEF_SQI_READ_CMD) begin
          fails++;
          $display("FAIL sqi_cmd: got %h, required %h", cmd_cap, DEF_SQI_READ_CMD);
        end
      end
      if (n == 7) begin
        checks++;
        if (addr_cap !== {7'b0, ep, 1'b0}) begin
          fails++;
          $display("FAIL sqi_addr: got %h, required %h", addr_cap, {7'b0, ep, 1'b0});
        end
      end
      sio_in = n >= 10 ? mem_nib(addr_cap[16:1] + 16'((n - 10) / 4), (n - 10) % 4) : 4'h0;
      n++;
    end
    if (rst === 1'b1) begin
      ep = RESET_PC;
      en = 0;
    end else if (redirect === 1'b1) begin
      ep = redirect_pc;
      en = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(output int k);
    k = 0;
    while (enc_vld !== 1'b1 && k < 40) begin
      step();
      @(negedge clk);
      k++;
    end
  endtask

  task automatic get_addr(output logic [23:0] a, output bit ok);
    int k;
    k = 0;
    a = '0;
    while (cs_n !== 1'b0 && k < 40) begin
      step();
      @(negedge clk);
      k++;
    end
    ok = k < 40;
    step();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      a = {a[19:0], sio_out};
    end
  endtask

  task automatic test_reset();
    logic [31:0] ca;
    int k;
    ca = {DEF_SQI_READ_CMD, 24'h0};
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({cs_n, sio_oe, sio_out} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_sqi: cs_n=%b oe=%b out=%h, required 1 0 0", cs_n, sio_oe, sio_out);
    end
    checks++;
    if (enc !== 4'h0 || enc_vld !== 1'b0 || pc !== RESET_PC) begin
      fails++;
      $display("FAIL reset_dec: enc=%h vld=%b pc=%h, required 0 0 %h", enc, enc_vld, pc, RESET_PC);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1) begin
      fails++;
      $display("FAIL idle_cycle: cs_n=%b, required 1", cs_n);
    end
    step();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        step();
        @(negedge clk);
      end
      checks++;
      if (cs_n !== 1'b0 || sio_oe !== (i < 8) || (i < 8 && sio_out !== ca[31-4*i -: 4])) begin
        fails++;
        $display("FAIL preamble_%0d: cs_n=%b oe=%b out=%h, required 0 %b %h", i, cs_n, sio_oe, sio_out, i < 8, i < 8 ? ca[31-4*i -: 4] : sio_out);
      end
    end
    k = 9;
    while (enc_vld !== 1'b1 && k < 40) begin
      step();
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 11) begin
      fails++;
      $display("FAIL first_latency: %0d cycles after cs fall, required 11", k);
    end
    checks++;
    if (enc !== 4'hA || pc !== 16'h0000) begin
      fails++;
      $display("FAIL first_nibble: enc=%h pc=%h, required a 0000", enc, pc);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        step();
        @(negedge clk);
      end
      checks++;
      if (enc_vld !== 1'b1 || cs_n !== 1'b0 || pc !== 16'(i / 4) || enc !== mem_nib(16'(i / 4), i % 4)) begin
        fails++;
        $display("FAIL stream_%0d: vld=%b cs_n=%b pc=%h enc=%h, required 1 0 %h %h", i, enc_vld, cs_n, pc, enc, 16'(i / 4), mem_nib(16'(i / 4), i % 4));
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] a;
    bit ok;
    int k;
    repeat (10) begin
      step();
      @(negedge clk);
    end
    step();
    stall = 1'b1;
    @(negedge clk);
    checks++;
    if (enc_vld !== 1'b1 || pc !== 16'h0005) begin
      fails++;
      $display("FAIL stall_pos: vld=%b pc=%h, required 1 0005", enc_vld, pc);
    end
    step();
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || enc_vld !== 1'b1) begin
      fails++;
      $display("FAIL stall_cs: cs_n=%b vld=%b, required 1 1", cs_n, enc_vld);
    end
    step();
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || enc_vld !== 1'b0) begin
      fails++;
      $display("FAIL stall_hold: cs_n=%b vld=%b, required 1 0", cs_n, enc_vld);
    end
    step();
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || enc_vld !== 1'b0) begin
      fails++;
      $display("FAIL stall_last: cs_n=%b vld=%b, required 1 0", cs_n, enc_vld);
    end
    get_addr(a, ok);
    checks++;
    if (!ok || a !== 24'h00000C) begin
      fails++;
      $display("FAIL stall_addr: ok=%b addr=%h, required 1 00000c", ok, a);
    end
    wait_vld(k);
    checks++;
    if (k >= 40 || pc !== 16'h0006 || enc !== mem_nib(16'h0006, 0)) begin
      fails++;
      $display("FAIL stall_resume: wait=%0d pc=%h enc=%h, required pc 0006 enc %h", k, pc, enc, mem_nib(16'h0006, 0));
    end
  endtask

  task automatic test_redirect();
    logic [23:0] a;
    bit ok;
    int k;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_vld(k);
    repeat (8) begin
      step();
      @(negedge clk);
    end
    step();
    redirect = 1'b1;
    redirect_pc = 16'h1234;
    @(negedge clk);
    checks++;
    if (enc_vld !== 1'b1 || pc !== 16'h0002 || enc !== mem_nib(16'h0002, 1)) begin
      fails++;
      $display("FAIL redir_pos: vld=%b pc=%h enc=%h, required 1 0002 %h", enc_vld, pc, enc, mem_nib(16'h0002, 1));
    end
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (enc_vld !== 1'b0 || cs_n !== 1'b1) begin
      fails++;
      $display("FAIL redir_flush: vld=%b cs_n=%b, required 0 1", enc_vld, cs_n);
    end
    get_addr(a, ok);
    checks++;
    if (!ok || a !== 24'h002468) begin
      fails++;
      $display("FAIL redir_addr: ok=%b addr=%h, required 1 002468", ok, a);
    end
    wait_vld(k);
    checks++;
    if (k >= 40 || pc !== 16'h1234) begin
      fails++;
      $display("FAIL redir_pc: wait=%0d pc=%h, required 1234", k, pc);
    end
  endtask

  task automatic test_wrap();
    logic [23:0] a;
    bit ok;
    int k;
    step();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    @(negedge clk);
    step();
    redirect = 1'b0;
    wait_vld(k);
    checks++;
    if (k >= 40 || pc !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_start: wait=%0d pc=%h, required ffff", k, pc);
    end
    repeat (3) begin
      step();
      @(negedge clk);
    end
    checks++;
    if (cs_n !== 1'b1 || enc_vld !== 1'b1) begin
      fails++;
      $display("FAIL wrap_cs: cs_n=%b vld=%b, required 1 1", cs_n, enc_vld);
    end
    step();
    @(negedge clk);
    checks++;
    if (pc !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_pc: pc=%h, required 0000", pc);
    end
    get_addr(a, ok);
    checks++;
    if (!ok || a !== 24'h000000) begin
      fails++;
      $display("FAIL wrap_addr: ok=%b addr=%h, required 1 000000", ok, a);
    end
    wait_vld(k);
    checks++;
    if (k >= 40 || pc !== 16'h0000 || enc !== 4'hA) begin
      fails++;
      $display("FAIL wrap_data: wait=%0d pc=%h enc=%h, required 0000 a", k, pc, enc);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    step();
    @(negedge clk);
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (enc_vld !== 1'b1 || enc !== 4'hC) begin
      fails++;
      $display("FAIL rstmid_pos: vld=%b enc=%h, required 1 c", enc_vld, enc);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cs_n, sio_oe, sio_out, enc, enc_vld} !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0} || pc !== RESET_PC) begin
      fails++;
      $display("FAIL rstmid_vals: cs_n=%b oe=%b out=%h enc=%h vld=%b pc=%h, required 1 0 0 0 0 %h", cs_n, sio_oe, sio_out, enc, enc_vld, pc, RESET_PC);
    end
    step();
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_cs: cs_n=%b, required 0", cs_n);
    end
    wait_vld(k);
    checks++;
    if (k != 11 || pc !== RESET_PC || enc !== 4'hA) begin
      fails++;
      $display("FAIL rstmid_refetch: latency=%0d pc=%h enc=%h, required 11 %h a", k, pc, enc, RESET_PC);
    end
  endtask

  task automatic test_redirect_stall();
    logic [23:0] a;
    bit ok;
    int k;
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    stall = 1'b1;
    @(negedge clk);
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || enc_vld !== 1'b0) begin
      fails++;
      $display("FAIL rs_flush: cs_n=%b vld=%b, required 1 0", cs_n, enc_vld);
    end
    step();
    @(negedge clk);
    step();
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1) begin
      fails++;
      $display("FAIL rs_hold: cs_n=%b, required 1", cs_n);
    end
    get_addr(a, ok);
    checks++;
    if (!ok || a !== 24'h000200) begin
      fails++;
      $display("FAIL rs_addr: ok=%b addr=%h, required 1 000200", ok, a);
    end
    wait_vld(k);
    checks++;
    if (k >= 40 || pc !== 16'h0100) begin
      fails++;
      $display("FAIL rs_pc: wait=%0d pc=%h, required 0100", k, pc);
    end
  endtask

  task automatic test_random();
    int k;
    logic [15:0] tgt;
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(1, 24)) begin
        step();
        stall = $urandom_range(0, 3) == 0;
        @(negedge clk);
      end
      tgt = 16'($urandom);
      step();
      stall = 1'b0;
      redirect = 1'b1;
      redirect_pc = tgt;
      @(negedge clk);
      step();
      redirect = 1'b0;
      wait_vld(k);
      checks++;
      if (k >= 40 || pc !== tgt) begin
        fails++;
        $display("FAIL rand_%0d: wait=%0d pc=%h, required %h", it, k, pc, tgt);
      end
    end
  endtask

  initial begin
    salt = 16'($urandom) | 16'h0001;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_redirect_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
